// File: rtl/tlul_pkg.sv
// TL-UL channel structs and opcode enums, sized from top_pkg.
package tlul_pkg;
    import top_pkg::*;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    // host -> device: A channel plus D-channel ready
    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_AUW-1:0] a_user;
        logic              d_ready;
    } tl_h2d_t;

    // device -> host: D channel plus A-channel ready
    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;
endpackage

// File: rtl/top_pkg.sv
// Top-level TL-UL width constants shared by every socket in the fabric.
package top_pkg;
    localparam int TL_AW  = 32;        // address bits
    localparam int TL_DW  = 32;        // data bits
    localparam int TL_AIW = 8;         // a_source / d_source bits
    localparam int TL_DIW = 1;         // d_sink bits
    localparam int TL_AUW = 16;        // a_user bits
    localparam int TL_DUW = 16;        // d_user bits
    localparam int TL_DBW = TL_DW / 8; // byte-mask bits
    localparam int TL_SZW = 2;         // size bits
endpackage

// File: rtl/tlul_host_arb_if.sv
// Bus bundle for tlul_host_arb.
//   tl_h_i  : per-host requests (a_*, d_ready)
//   tl_h_o  : per-host responses (d_*, a_ready)
//   tl_d_o  : device-side request
//   tl_d_i  : device-side response
//   gnt_o   : one-hot A-channel owner
//   err_o   : unroutable / underflowing D beat
// slave = the arbiter side, master = the hosts/device side driving it.
interface tlul_host_arb_if #(
    parameter int NumHosts = 2
);
    import tlul_pkg::*;

    tl_h2d_t               tl_h_i [NumHosts];
    tl_d2h_t               tl_h_o [NumHosts];
    tl_h2d_t               tl_d_o;
    tl_d2h_t               tl_d_i;
    logic [NumHosts-1:0]   gnt_o;
    logic                  err_o;

    modport slave  (input  tl_h_i, tl_d_i, output tl_h_o, tl_d_o, gnt_o, err_o);
    modport master (output tl_h_i, tl_d_i, input  tl_h_o, tl_d_o, gnt_o, err_o);
endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping. Works for any N (no power-of-two assumption).
//   req_i : request vector      ptr_i : highest-priority index
//   gnt_o : one-hot winner      idx_o : winner index, vld_o : any winner
module rr_arb #(
    parameter int N = 2,
    localparam int IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            vld_o
);
    always_comb begin
        int j;
        logic [IdxW-1:0] j_idx;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        j_idx = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            j_idx = IdxW'(j);
            if (!vld_o && req_i[j_idx]) begin
                vld_o        = 1'b1;
                gnt_o[j_idx] = 1'b1;
                idx_o        = j_idx;
            end
        end
    end
endmodule

// File: rtl/tlul_host_arb.sv
// Shares one TL-UL device port among NumHosts hosts.
//   clk_i, rst_i : clock, async active-high reset
//   bus          : tlul_host_arb_if.slave (host/device channels, gnt_o, err_o)
// A channel: round-robin with a lock that holds the grant while the device
// back-pressures. D channel: routed by the host ID placed in the top IdW
// bits of a_source. Each host is limited to MaxOutHost outstanding requests.
module tlul_host_arb
    import top_pkg::*;
    import tlul_pkg::*;
#(
    parameter int NumHosts   = 2,
    parameter int MaxOutHost = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    tlul_host_arb_if.slave bus
);
    localparam int IdW  = $clog2(NumHosts);
    localparam int CntW = $clog2(MaxOutHost + 1);

    if (NumHosts < 2)       $error("NumHosts must be >= 2");
    if (IdW > TL_AIW - 1)   $error("host ID does not fit in a_source");

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    arb_state_e          state_q, state_d;
    logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]      lock_id_q, lock_id_d;
    logic [CntW-1:0]     out_cnt_q [NumHosts];
    logic [CntW-1:0]     out_cnt_d [NumHosts];

    logic [NumHosts-1:0] req, arb_gnt, gnt;
    logic [IdW-1:0]      arb_idx, sel, d_id;
    logic                arb_vld, a_hs, d_ok, dev_d_ready, err;
    logic                inc, dec;
    tl_h2d_t             a_fwd;
    tl_d2h_t             d_rsp;
    tl_d2h_t             h_o [NumHosts];

    function automatic logic [IdW-1:0] ptr_next(input logic [IdW-1:0] p);
        return (p == IdW'(NumHosts - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NumHosts; i++)
            req[i] = bus.tl_h_i[i].a_valid && (out_cnt_q[i] < CntW'(MaxOutHost));
    end

    rr_arb #(.N(NumHosts)) u_rr_arb (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_comb begin
        // A channel select: the lock overrides the picker
        gnt = '0;
        sel = arb_idx;
        if (state_q == LOCKED) begin
            sel      = lock_id_q;
            gnt[sel] = 1'b1;
        end else if (arb_vld) begin
            gnt = arb_gnt;
        end

        a_fwd          = bus.tl_h_i[sel];
        a_fwd.a_source = {sel, bus.tl_h_i[sel].a_source[TL_AIW-IdW-1:0]};
        a_fwd.a_valid  = (|gnt) & bus.tl_h_i[sel].a_valid;
        a_hs           = a_fwd.a_valid & bus.tl_d_i.a_ready;

        // D channel routing; an unroutable beat is sunk so the device never stalls
        d_id        = bus.tl_d_i.d_source[TL_AIW-1 -: IdW];
        d_ok        = int'(d_id) < NumHosts;
        dev_d_ready = 1'b1;
        d_rsp       = bus.tl_d_i;
        d_rsp.d_source[TL_AIW-1 -: IdW] = '0;
        err         = bus.tl_d_i.d_valid & ~d_ok;

        for (int i = 0; i < NumHosts; i++) begin
            h_o[i]         = d_rsp;
            h_o[i].d_valid = bus.tl_d_i.d_valid & d_ok & (d_id == IdW'(i));
            h_o[i].a_ready = gnt[i] & bus.tl_d_i.a_ready;
            if (d_id == IdW'(i)) dev_d_ready = bus.tl_h_i[i].d_ready;

            inc = gnt[i] & a_hs;
            dec = h_o[i].d_valid & bus.tl_h_i[i].d_ready;
            // a response for a host with nothing outstanding (e.g. after reset)
            if (dec && out_cnt_q[i] == '0) begin
                err = 1'b1;
                dec = 1'b0;
            end
            out_cnt_d[i] = out_cnt_q[i] + CntW'(inc) - CntW'(dec);
        end
        a_fwd.d_ready = dev_d_ready;

        // FSM
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        case (state_q)
            IDLE: if (a_fwd.a_valid) begin
                if (a_hs) rr_ptr_d = ptr_next(sel);
                else begin
                    state_d   = LOCKED;
                    lock_id_d = sel;
                end
            end
            LOCKED: if (a_hs) begin
                state_d  = IDLE;
                rr_ptr_d = ptr_next(lock_id_q);
            end
            default: state_d = IDLE;
        endcase

        // everything handshake-related is quiet while reset is held
        if (rst_i) begin
            gnt           = '0;
            err           = 1'b0;
            a_fwd.a_valid = 1'b0;
            a_fwd.d_ready = 1'b0;
            for (int i = 0; i < NumHosts; i++) begin
                h_o[i].d_valid = 1'b0;
                h_o[i].a_ready = 1'b0;
            end
        end
    end

    assign bus.tl_d_o = a_fwd;
    assign bus.tl_h_o = h_o;
    assign bus.gnt_o  = gnt;
    assign bus.err_o  = err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            for (int i = 0; i < NumHosts; i++) out_cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            for (int i = 0; i < NumHosts; i++) out_cnt_q[i] <= out_cnt_d[i];
        end
    end
endmodule

// File: tb/tb_tlul_host_arb.sv
// Directed bench for tlul_host_arb. Main DUT has 2 hosts / MaxOutHost=4;
// a 3-host instance covers the unroutable-ID case, since with 2 hosts every
// 1-bit ID value names a real host.
module tb_tlul_host_arb;
    import tlul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tlul_host_arb_if #(.NumHosts(2)) bus ();
    tlul_host_arb_if #(.NumHosts(3)) bus3 ();

    tlul_host_arb #(.NumHosts(2), .MaxOutHost(4)) dut (
        .clk_i (clk), .rst_i (rst), .bus (bus.slave));
    tlul_host_arb #(.NumHosts(3), .MaxOutHost(4)) dut3 (
        .clk_i (clk), .rst_i (rst), .bus (bus3.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance one cycle; inputs change 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_beat(input logic v, input logic [7:0] src);
        bus.tl_d_i.d_valid  = v;
        bus.tl_d_i.d_source = src;
        bus.tl_d_i.d_opcode = AccessAckData;
        bus.tl_d_i.d_data   = 32'hCAFE_0000 | 32'(src);
    endtask

    typedef struct {
        logic [1:0]  av;    // host a_valid {h1,h0}
        logic        ardy;  // device a_ready
        logic [1:0]  gnt;   // expected gnt_o
        logic [1:0]  hrdy;  // expected host a_ready {h1,h0}
        logic        dav;   // expected device a_valid
        logic [7:0]  src;   // expected device a_source
        logic [31:0] addr;  // expected device a_address
    } vec_t;

    vec_t tv [12];

    initial begin
        // fairness: grants alternate 0,1,...
        for (int k = 0; k < 6; k++)
            tv[k] = '{2'b11, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b10,
                      (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1,
                      (k % 2 == 0) ? 8'h11 : 8'h85,
                      (k % 2 == 0) ? 32'h1000 : 32'h2000};
        // lock under backpressure, then acceptance, then host1
        for (int k = 6; k < 9; k++)
            tv[k] = '{2'b11, 1'b0, 2'b01, 2'b00, 1'b1, 8'h11, 32'h1000};
        tv[9]  = '{2'b11, 1'b1, 2'b01, 2'b01, 1'b1, 8'h11, 32'h1000};
        tv[10] = '{2'b11, 1'b1, 2'b10, 2'b10, 1'b1, 8'h85, 32'h2000};
        // both hosts now hold 4 outstanding: nobody eligible
        tv[11] = '{2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 32'h0};

        for (int i = 0; i < 2; i++) bus.tl_h_i[i] = '0;
        for (int i = 0; i < 3; i++) bus3.tl_h_i[i] = '0;
        bus.tl_d_i  = '0;
        bus3.tl_d_i = '0;
        bus.tl_h_i[0].a_source  = 8'h11;
        bus.tl_h_i[0].a_address = 32'h1000;
        bus.tl_h_i[0].a_opcode  = PutFullData;
        bus.tl_h_i[1].a_source  = 8'h05;
        bus.tl_h_i[1].a_address = 32'h2000;
        bus.tl_h_i[1].a_opcode  = Get;

        // reset state with requests pending
        bus.tl_h_i[0].a_valid = 1'b1;
        bus.tl_h_i[1].a_valid = 1'b1;
        bus.tl_d_i.a_ready    = 1'b1;
        d_beat(1'b1, 8'h80);
        #2;
        chk("rst.gnt", bus.gnt_o, 2'b00);
        chk("rst.dev_avalid", bus.tl_d_o.a_valid, 1'b0);
        chk("rst.dev_dready", bus.tl_d_o.d_ready, 1'b0);
        chk("rst.h0_ardy", bus.tl_h_o[0].a_ready, 1'b0);
        chk("rst.h1_dvalid", bus.tl_h_o[1].d_valid, 1'b0);
        chk("rst.err", bus.err_o, 1'b0);
        tick();
        bus.tl_h_i[0].a_valid = 1'b0;
        bus.tl_h_i[1].a_valid = 1'b0;
        d_beat(1'b0, 8'h00);
        rst = 1'b0;
        tick();

        // single host: host1 Get with source 05 -> device sees 85
        bus.tl_h_i[1].a_valid = 1'b1;
        #2;
        chk("single.gnt", bus.gnt_o, 2'b10);
        chk("single.src", bus.tl_d_o.a_source, 8'h85);
        chk("single.op", bus.tl_d_o.a_opcode, Get);
        chk("single.h1_ardy", bus.tl_h_o[1].a_ready, 1'b1);
        tick();
        bus.tl_h_i[1].a_valid = 1'b0;
        bus.tl_h_i[1].d_ready = 1'b1;
        d_beat(1'b1, 8'h85);
        #2;
        chk("single.h1_dvalid", bus.tl_h_o[1].d_valid, 1'b1);
        chk("single.h1_dsrc", bus.tl_h_o[1].d_source, 8'h05);
        chk("single.h1_ddata", bus.tl_h_o[1].d_data, 32'hCAFE_0085);
        chk("single.h0_dvalid", bus.tl_h_o[0].d_valid, 1'b0);
        chk("single.dev_dready", bus.tl_d_o.d_ready, 1'b1);
        chk("single.err", bus.err_o, 1'b0);
        tick();
        d_beat(1'b0, 8'h00);

        // table: fairness, lock, outstanding mask
        for (int k = 0; k < 12; k++) begin
            bus.tl_h_i[0].a_valid = tv[k].av[0];
            bus.tl_h_i[1].a_valid = tv[k].av[1];
            bus.tl_d_i.a_ready    = tv[k].ardy;
            #2;
            chk($sformatf("tv%0d.gnt", k), bus.gnt_o, tv[k].gnt);
            chk($sformatf("tv%0d.hrdy", k),
                {bus.tl_h_o[1].a_ready, bus.tl_h_o[0].a_ready}, tv[k].hrdy);
            chk($sformatf("tv%0d.dav", k), bus.tl_d_o.a_valid, tv[k].dav);
            if (tv[k].dav) begin
                chk($sformatf("tv%0d.src", k), bus.tl_d_o.a_source, tv[k].src);
                chk($sformatf("tv%0d.addr", k), bus.tl_d_o.a_address, tv[k].addr);
            end
            tick();
        end

        // outstanding limit on host0 (count 4); host1 idle
        bus.tl_h_i[1].a_valid = 1'b0;
        bus.tl_h_i[0].a_valid = 1'b1;
        bus.tl_h_i[0].d_ready = 1'b1;
        bus.tl_d_i.a_ready    = 1'b1;
        d_beat(1'b1, 8'h00);                       // 4 -> 3
        #2;
        chk("lim.c1.gnt", bus.gnt_o, 2'b00);
        chk("lim.c1.h0_ardy", bus.tl_h_o[0].a_ready, 1'b0);
        chk("lim.c1.h0_dvalid", bus.tl_h_o[0].d_valid, 1'b1);
        tick();
        d_beat(1'b0, 8'h00);                       // A: 3 -> 4
        #2; chk("lim.c2.gnt", bus.gnt_o, 2'b01); tick();
        #2; chk("lim.c3.gnt", bus.gnt_o, 2'b00); tick();
        d_beat(1'b1, 8'h00);                       // 4 -> 3
        #2; chk("lim.c4.gnt", bus.gnt_o, 2'b00); tick();
        #2; chk("lim.c5.gnt", bus.gnt_o, 2'b01);   // A+D: stays 3
        chk("lim.c5.dev_dready", bus.tl_d_o.d_ready, 1'b1);
        tick();
        d_beat(1'b0, 8'h00);                       // A: 3 -> 4
        #2; chk("lim.c6.gnt", bus.gnt_o, 2'b01); tick();
        #2; chk("lim.c7.gnt", bus.gnt_o, 2'b00); tick();
        bus.tl_h_i[0].a_valid = 1'b0;

        // response after reset: routed, but counter underflow flags err
        rst = 1'b1; tick(); rst = 1'b0; tick();
        d_beat(1'b1, 8'h00);
        #2;
        chk("uflow.h0_dvalid", bus.tl_h_o[0].d_valid, 1'b1);
        chk("uflow.err", bus.err_o, 1'b1);
        tick();
        d_beat(1'b0, 8'h00);
        #2; chk("uflow.err_clear", bus.err_o, 1'b0);
        tick();

        // unroutable ID on the 3-host instance (ID 3)
        bus3.tl_d_i.d_valid  = 1'b1;
        bus3.tl_d_i.d_source = 8'hC0;
        #2;
        chk("badid.dev_dready", bus3.tl_d_o.d_ready, 1'b1);
        chk("badid.err", bus3.err_o, 1'b1);
        chk("badid.dvalids", {bus3.tl_h_o[2].d_valid, bus3.tl_h_o[1].d_valid,
                              bus3.tl_h_o[0].d_valid}, 3'b000);
        tick();
        bus3.tl_d_i.d_valid = 1'b0;
        #2; chk("badid.err_clear", bus3.err_o, 1'b0);
        tick();

        // reset while locked on host1 (rr_ptr=1 after host0 is served)
        bus.tl_h_i[0].a_valid = 1'b1;
        bus.tl_d_i.a_ready    = 1'b1;
        #2; chk("rlock.h0_first", bus.gnt_o, 2'b01);
        tick();
        bus.tl_h_i[1].a_valid = 1'b1;
        bus.tl_d_i.a_ready    = 1'b0;
        tick();
        #2; chk("rlock.locked_h1", bus.gnt_o, 2'b10);
        d_beat(1'b1, 8'h80);
        bus.tl_h_i[1].d_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rlock.gnt", bus.gnt_o, 2'b00);
        chk("rlock.dev_avalid", bus.tl_d_o.a_valid, 1'b0);
        chk("rlock.dev_dready", bus.tl_d_o.d_ready, 1'b0);
        chk("rlock.h1_dvalid", bus.tl_h_o[1].d_valid, 1'b0);
        tick();
        d_beat(1'b0, 8'h00);
        rst = 1'b0;
        bus.tl_d_i.a_ready = 1'b1;
        #2; chk("rlock.h0_wins", bus.gnt_o, 2'b01);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
